// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: op encodings, FSM state type
// and the default data width.
package div_iter_pkg;

   localparam int XLEN_DEF = 32;

   // op[0] selects unsigned, op[1] selects remainder
   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left and subtract the divisor
// when the shifted remainder covers it.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;
   logic          ge;

   assign shifted = {rem_i, quo_i[XLEN-1]};
   assign diff    = shifted - {1'b0, divisor_i};

   // rem_i < divisor_i always holds, so shifted < 2*divisor and the top bit
   // of the difference is exactly the borrow.
   assign ge    = ~diff[XLEN];
   assign rem_o = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   assign quo_o = {quo_i[XLEN-2:0], ge};

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle RV-style divider (DIV/DIVU/REM/REMU): one quotient bit per cycle,
// then a sign fix-up cycle, with early-out for divide-by-zero and overflow.
module div_iter_unit
   import div_iter_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int ITERS = XLEN
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            busy,
   output logic            div_stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(ITERS + 1);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvsr_q, dvsr_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [1:0]      op_q, op_d;
   logic            neg_a_q, neg_a_d;
   logic            neg_b_q, neg_b_d;

   logic            in_signed;
   logic            in_neg_a;
   logic            in_neg_b;
   logic [XLEN-1:0] step_rem;
   logic [XLEN-1:0] step_quo;
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;

   div_step #(.XLEN(XLEN)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvsr_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   assign in_signed = ~op[0];
   assign in_neg_a  = in_signed & rs1[XLEN-1];
   assign in_neg_b  = in_signed & rs2[XLEN-1];

   assign quo_fix = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
   assign rem_fix = neg_a_q ? -rem_q : rem_q;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvsr_d   = dvsr_q;
      result_d = result_q;
      op_d     = op_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = op;
               neg_a_d = in_neg_a;
               neg_b_d = in_neg_b;
               if (rs2 == '0) begin
                  result_d = op[1] ? rs1 : '1;
                  state_d  = ST_DONE;
               end else if (in_signed && rs1 == INT_MIN && rs2 == '1) begin
                  result_d = op[1] ? '0 : INT_MIN;
                  state_d  = ST_DONE;
               end else begin
                  rem_d   = '0;
                  quo_d   = in_neg_a ? -rs1 : rs1;
                  dvsr_d  = in_neg_b ? -rs2 : rs2;
                  count_d = CW'(ITERS - 1);
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            if (count_q == '0) state_d = ST_FIX;
            else               count_d = count_q - 1'b1;
         end
         ST_FIX: begin
            result_d = op_q[1] ? rem_fix : quo_fix;
            state_d  = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Abandon wins over everything, including a same-cycle start.
      if (flush) begin
         state_d  = ST_IDLE;
         result_d = result_q;
      end
   end

   // NOTE: the datapath registers are reset along with the control state so
   // that result reads as zero straight out of reset, not just the FSM.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         result_q <= '0;
         op_q     <= OP_DIV;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q  <= state_d;
         count_q  <= count_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvsr_q   <= dvsr_d;
         result_q <= result_d;
         op_q     <= op_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
      end
   end

   assign busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
   assign div_stall = (start && (state_q == ST_IDLE)) || busy;
   assign done      = (state_q == ST_DONE);
   assign result    = result_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: expected results and due cycles are queued
// at issue and checked when done pulses.
module tb_div_iter_unit;
   import div_iter_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic            start = 1'b0;
   logic [1:0]      op = 2'b00;
   logic [XLEN-1:0] rs1 = '0;
   logic [XLEN-1:0] rs2 = '0;
   logic            flush = 1'b0;
   logic            busy;
   logic            div_stall;
   logic            done;
   logic [XLEN-1:0] result;

   div_iter_unit #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .op        (op),
      .rs1       (rs1),
      .rs2       (rs2),
      .flush     (flush),
      .busy      (busy),
      .div_stall (div_stall),
      .done      (done),
      .result    (result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [XLEN-1:0] res;
      int              due;
   } exp_t;

   exp_t            sb[$];
   exp_t            mon_e;
   int              n_checks = 0;
   int              n_fail = 0;
   logic [XLEN-1:0] last_res = '0;
   int              t0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (resetn === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("result", result, mon_e.res);
            check("done_cycle", cyc, mon_e.due);
         end
      end
   end

   // Issue one op, optionally poke a stray start at T+poke, and wait for done.
   task automatic run(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] exp, input int lat, input int poke);
      int t;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      rs1   = a;
      rs2   = b;
      t     = cyc;
      #1 check("stall_on_start", div_stall, 1);
      sb.push_back('{res: exp, due: t + lat});
      for (int i = 1; i <= lat + 5; i++) begin
         @(negedge clk);
         #2;
         if (i == 1) begin
            rs1 = $urandom;
            rs2 = $urandom;
            op  = 2'($urandom);
         end
         if (poke > 0 && cyc == t + poke) begin
            start = 1'b1;
            op    = OP_DIV;
            rs1   = 32'd5;
            rs2   = 32'd1;
         end else begin
            start = 1'b0;
         end
         check("busy", busy, (cyc < t + lat) ? 1 : 0);
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         check("timeout_pending", sb.size(), 0);
         sb.delete();
      end
      last_res = exp;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_stall", div_stall, 0);
      @(negedge clk);
      resetn = 1'b1;

      run(OP_DIV,  32'd100, 32'd7, 32'd14, 34, 0);
      run(OP_REM,  32'd100, 32'd7, 32'd2,  34, 0);
      run(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
      run(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
      run(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34, 0);
      run(OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1,         34, 0);
      run(OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        34, 0);
      run(OP_REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34, 0);

      run(OP_DIV,  32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
      run(OP_REM,  32'h1234, 32'd0, 32'h1234,      1, 0);
      run(OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
      run(OP_REMU, 32'h1234, 32'd0, 32'h1234,      1, 0);
      run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);
      run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, 0);
      run(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);

      // Stray starts while busy and while in DONE must be ignored.
      run(OP_DIVU, 32'd1000, 32'd10, 32'd100, 34, 5);
      run(OP_REMU, 32'd1000, 32'd7,  32'd6,   34, 34);
      run(OP_DIV,  32'd77,   32'd11, 32'd7,   34, 0);

      // Flush mid-CALC: back to IDLE, no done, result untouched.
      @(negedge clk);
      start = 1'b1; op = OP_DIV; rs1 = 32'd100; rs2 = 32'd7; t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_cycle", cyc, t0 + 11);
      check("flush_busy", busy, 0);
      check("flush_result", result, last_res);
      repeat (30) @(negedge clk);
      check("flush_result_held", result, last_res);

      // Flush together with a start in IDLE wins, even for an early-out case.
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = OP_DIV; rs1 = 32'h1234; rs2 = 32'd0;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check("flush_start_done", done, 0);
      check("flush_start_busy", busy, 0);
      check("flush_start_result", result, last_res);

      run(OP_REM, 32'd100, 32'd7, 32'd2, 34, 0);

      // Asynchronous reset mid-CALC clears outputs without a clock edge.
      @(negedge clk);
      start = 1'b1; op = OP_DIV; rs1 = 32'd100; rs2 = 32'd7; t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      check("pre_reset_busy", busy, 1);
      #2 resetn = 1'b0;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_result", result, 0);
      check("async_rst_done", done, 0);
      check("async_rst_stall", div_stall, 0);
      @(negedge clk);
      resetn = 1'b1;
      last_res = '0;
      check("post_rst_result", result, 0);

      run(OP_DIV, 32'd100, 32'd7, 32'd14, 34, 0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
